// File: rtl/acumulador_pkg.sv
// Shared definitions for the accumulator slice: FSM state encoding and
// the two's-complement overflow test used by any adder-based stage.
package acumulador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Signed overflow of a+b=s: both operands share a sign and the result's
  // sign differs from it. Only the sign bits are needed, so the function is
  // independent of operand width.
  function automatic logic desborde_signo(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/sumadorNBits.sv
// N-bit ripple-carry adder: s = a + b + c_in, with unsigned carry-out.
module sumadorNBits #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] acarreo;

  assign acarreo[0] = c_in;

  // One full-adder cell per bit, chained through acarreo.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_celda
      assign s[gi]           = a[gi] ^ b[gi] ^ acarreo[gi];
      assign acarreo[gi + 1] = (a[gi] & b[gi]) | (acarreo[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = acarreo[N];

endmodule

// File: rtl/acumulador_nbits.sv
// Handshaked multi-cycle accumulator. The registered sum is fed back into
// sumadorNBits as operand a; carry and signed overflow are collected as
// sticky flags for the run. A run ends after MAX_CUENTA operands or on fin,
// and the result is held with out_valid until the consumer takes it.
module acumulador_nbits
  import acumulador_pkg::*;
#(
  parameter int N          = 8,
  parameter int MAX_CUENTA = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            fin,
  input  logic [N-1:0]                    dato,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [N-1:0]                    resultado,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            carry,
  output logic                            overflow,
  output logic                            cero,
  output logic [$clog2(MAX_CUENTA+1)-1:0] cuenta
);

  localparam int CW = $clog2(MAX_CUENTA + 1);
  localparam logic [CW-1:0] ULTIMA = CW'(MAX_CUENTA - 1);

  estado_t       estado_reg,    estado_next;
  logic [N-1:0]  resultado_reg, resultado_next;
  logic          carry_reg,     carry_next;
  logic          overflow_reg,  overflow_next;
  logic [CW-1:0] cuenta_reg,    cuenta_next;

  logic [N-1:0]  suma;
  logic          suma_cout;
  logic          aceptar;

  // The running sum is always operand a; dato is b. No carry-in.
  sumadorNBits #(.N(N)) u_sumador (
    .a     (resultado_reg),
    .b     (dato),
    .c_in  (1'b0),
    .s     (suma),
    .c_out (suma_cout)
  );

  assign in_ready  = (estado_reg == ACUM);
  assign out_valid = (estado_reg == DONE);
  assign aceptar   = in_valid && in_ready;

  // State, accumulator, flags and counter; all cleared on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg    <= IDLE;
      resultado_reg <= '0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      cuenta_reg    <= '0;
    end else begin
      estado_reg    <= estado_next;
      resultado_reg <= resultado_next;
      carry_reg     <= carry_next;
      overflow_reg  <= overflow_next;
      cuenta_reg    <= cuenta_next;
    end
  end

  // Next-state and datapath update; everything holds unless changed below.
  always_comb begin
    estado_next    = estado_reg;
    resultado_next = resultado_reg;
    carry_next     = carry_reg;
    overflow_next  = overflow_reg;
    cuenta_next    = cuenta_reg;

    case (estado_reg)
      IDLE: begin
        // Previous result stays visible until a new run clears it.
        if (start) begin
          resultado_next = '0;
          carry_next     = 1'b0;
          overflow_next  = 1'b0;
          cuenta_next    = '0;
          estado_next    = ACUM;
        end
      end

      ACUM: begin
        // An operand presented together with fin is still added.
        if (aceptar) begin
          resultado_next = suma;
          carry_next     = carry_reg | suma_cout;
          overflow_next  = overflow_reg |
                           desborde_signo(resultado_reg[N-1], dato[N-1], suma[N-1]);
          cuenta_next    = cuenta_reg + 1'b1;
        end
        if ((aceptar && (cuenta_reg == ULTIMA)) || fin) begin
          estado_next = DONE;
        end
      end

      DONE: begin
        // start is deliberately not looked at here, even on the handshake.
        if (out_ready) begin
          estado_next = IDLE;
        end
      end

      default: begin
        estado_next = IDLE;
      end
    endcase
  end

  assign resultado = resultado_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;
  assign cuenta    = cuenta_reg;
  assign cero      = (resultado_reg == '0);

endmodule

// File: tb/tb_acumulador_nbits.sv
// Directed bench for acumulador_nbits (N=8, MAX_CUENTA=4). Inputs change
// 1 ns after each rising edge; outputs are sampled at the same point.
module tb_acumulador_nbits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       fin;
  logic [7:0] dato;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] resultado;
  logic       out_valid;
  logic       out_ready;
  logic       carry;
  logic       overflow;
  logic       cero;
  logic [2:0] cuenta;

  int checks = 0;
  int errors = 0;
  int ciclo  = 0;

  acumulador_nbits #(.N(8), .MAX_CUENTA(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fin       (fin),
    .dato      (dato),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .resultado (resultado),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .carry     (carry),
    .overflow  (overflow),
    .cero      (cero),
    .cuenta    (cuenta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic chk_all(input string tag, input logic [7:0] e_res, input logic e_c,
                         input logic e_o, input logic e_z, input logic [2:0] e_cnt,
                         input logic e_ir, input logic e_ov);
    chk({tag, ".resultado"}, 32'(resultado), 32'(e_res));
    chk({tag, ".carry"},     32'(carry),     32'(e_c));
    chk({tag, ".overflow"},  32'(overflow),  32'(e_o));
    chk({tag, ".cero"},      32'(cero),      32'(e_z));
    chk({tag, ".cuenta"},    32'(cuenta),    32'(e_cnt));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ciclo++;
    $display("cyc %0d start=%b fin=%b vin=%b dato=%h ordy=%b | ir=%b ov=%b res=%h c=%b o=%b z=%b n=%0d",
             ciclo, start, fin, in_valid, dato, out_ready,
             in_ready, out_valid, resultado, carry, overflow, cero, cuenta);
  endtask

  task automatic idle_inputs();
    start = 0; fin = 0; in_valid = 0; dato = 8'h00; out_ready = 0;
  endtask

  task automatic feed(input logic [7:0] d, input logic f);
    in_valid = 1; dato = d; fin = f;
    tick();
    in_valid = 0; fin = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic take_result();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    chk_all("reset", 8'h00, 0, 0, 1, 3'd0, 0, 0);
    rst_n = 1;
    tick();

    // Basic accumulation: 5+3+10+1 = 0x13, auto-end after fourth operand.
    do_start();
    chk_all("basic_start", 8'h00, 0, 0, 1, 3'd0, 1, 0);
    feed(8'h05, 0);
    chk_all("basic_1", 8'h05, 0, 0, 0, 3'd1, 1, 0);
    feed(8'h03, 0);
    chk_all("basic_2", 8'h08, 0, 0, 0, 3'd2, 1, 0);
    feed(8'h0A, 0);
    chk_all("basic_3", 8'h12, 0, 0, 0, 3'd3, 1, 0);
    feed(8'h01, 0);
    chk_all("basic_done", 8'h13, 0, 0, 0, 3'd4, 0, 1);

    // DONE: backpressure with start and a pending operand; nothing moves.
    start = 1; in_valid = 1; dato = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("hold_done", 8'h13, 0, 0, 0, 3'd4, 0, 1);
    end
    // Handshake with start still high: start must be ignored.
    out_ready = 1;
    tick();
    out_ready = 0; start = 0;
    chk_all("to_idle", 8'h13, 0, 0, 0, 3'd4, 0, 0);
    // IDLE: operand is not consumed.
    tick();
    chk_all("idle_hold", 8'h13, 0, 0, 0, 3'd4, 0, 0);
    in_valid = 0;

    // Unsigned wrap: 0xFF + 0x01 -> 0x00 with carry, then fin.
    do_start();
    chk_all("wrap_start", 8'h00, 0, 0, 1, 3'd0, 1, 0);
    feed(8'hFF, 0);
    chk_all("wrap_1", 8'hFF, 0, 0, 0, 3'd1, 1, 0);
    feed(8'h01, 0);
    chk_all("wrap_2", 8'h00, 1, 0, 1, 3'd2, 1, 0);
    fin = 1;
    tick();
    fin = 0;
    chk_all("wrap_done", 8'h00, 1, 0, 1, 3'd2, 0, 1);
    take_result();
    chk_all("wrap_idle", 8'h00, 1, 0, 1, 3'd2, 0, 0);

    // New start clears sticky carry.
    do_start();
    chk_all("clear_flags", 8'h00, 0, 0, 1, 3'd0, 1, 0);

    // Signed overflow: 0x7F + 0x01 with fin on the same accept.
    feed(8'h7F, 0);
    chk_all("ovf_1", 8'h7F, 0, 0, 0, 3'd1, 1, 0);
    feed(8'h01, 1);
    chk_all("ovf_done", 8'h80, 0, 1, 0, 3'd2, 0, 1);
    take_result();

    // Empty run: fin without operands.
    do_start();
    fin = 1;
    tick();
    fin = 0;
    chk_all("empty_done", 8'h00, 0, 0, 1, 3'd0, 0, 1);
    take_result();
    chk_all("empty_idle", 8'h00, 0, 0, 1, 3'd0, 0, 0);

    // Asynchronous reset mid-run: 0x40 + 0x40 = 0x80 with overflow, then reset.
    do_start();
    feed(8'h40, 0);
    feed(8'h40, 0);
    chk_all("pre_reset", 8'h80, 0, 1, 0, 3'd2, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk_all("async_reset", 8'h00, 0, 0, 1, 3'd0, 0, 0);
    #3;
    rst_n = 1;
    tick();
    chk_all("post_reset_idle", 8'h00, 0, 0, 1, 3'd0, 0, 0);

    // Normal run after reset: 2+3, fin on the second operand.
    do_start();
    feed(8'h02, 0);
    feed(8'h03, 1);
    chk_all("after_reset_done", 8'h05, 0, 0, 0, 3'd2, 0, 1);
    take_result();
    chk_all("after_reset_idle", 8'h05, 0, 0, 0, 3'd2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
